// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: continuous run, counted run and ADC-driven AUTO mode.
// Pulse high time is a quarter of the active period; outputs are registered.
module step_pulse_gen #(
    parameter int unsigned W          = 16,
    parameter int unsigned DEF_PERIOD = 2000,
    parameter int unsigned MIN_PERIOD = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d_v,
    input  logic         drv_en,
    input  logic         cmd_start,
    input  logic         cmd_start_n,
    input  logic         cmd_stop,
    input  logic         cmd_auto,
    input  logic         invert,
    input  logic [W-1:0] period_in,
    input  logic [W-1:0] n_pulses,
    output logic         step_out,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] pulse_cnt,
    output logic [1:0]   state
);

    localparam logic [W-1:0] DEF_P = W'(DEF_PERIOD);
    localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_RUN_N = 2'd2,
        ST_AUTO  = 2'd3
    } state_t;

    state_t       st;
    logic [W-1:0] ph;
    logic [W-1:0] cur_p;
    logic [W-1:0] shadow;

    logic active_c;
    logic gen_c;
    logic boundary_c;
    logic exit_c;
    logic raw_c;

    function automatic logic [W-1:0] clamp_p(input logic [W-1:0] p);
        return (p < MIN_P) ? MIN_P : p;
    endfunction

    // Phase decode; an exiting state drives the idle level on the same edge.
    always_comb begin
        active_c   = (st != ST_IDLE);
        gen_c      = active_c && !((st == ST_AUTO) && !drv_en);
        boundary_c = gen_c && (ph == (cur_p - W'(1)));
        exit_c     = active_c && (cmd_stop || ((st == ST_AUTO) && !cmd_auto));
        raw_c      = gen_c && !exit_c && (ph < (cur_p >> 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ST_IDLE;
            ph        <= '0;
            cur_p     <= clamp_p(DEF_P);
            shadow    <= DEF_P;
            pulse_cnt <= '0;
            step_out  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            step_out <= raw_c ^ invert;
            if (d_v) begin
                shadow <= period_in;
            end

            case (st)
                ST_IDLE: begin
                    if (cmd_stop) begin
                        st <= ST_IDLE;
                    end else if (cmd_auto) begin
                        st    <= ST_AUTO;
                        ph    <= '0;
                        cur_p <= clamp_p(shadow);
                        busy  <= 1'b1;
                    end else if (cmd_start) begin
                        st    <= ST_RUN;
                        ph    <= '0;
                        cur_p <= clamp_p(DEF_P);
                        busy  <= 1'b1;
                    end else if (cmd_start_n) begin
                        if (n_pulses == '0) begin
                            done <= 1'b1;
                        end else begin
                            st        <= ST_RUN_N;
                            ph        <= '0;
                            cur_p     <= clamp_p(DEF_P);
                            pulse_cnt <= n_pulses;
                            busy      <= 1'b1;
                        end
                    end
                end

                ST_RUN, ST_RUN_N, ST_AUTO: begin
                    if (exit_c) begin
                        st        <= ST_IDLE;
                        ph        <= '0;
                        pulse_cnt <= '0;
                        busy      <= 1'b0;
                    end else if (!gen_c) begin
                        ph <= '0;
                    end else if (boundary_c) begin
                        ph <= '0;
                        // AUTO only picks up a new period at a boundary.
                        if (st == ST_AUTO) begin
                            cur_p <= clamp_p(shadow);
                        end
                        if (st == ST_RUN_N) begin
                            if (pulse_cnt <= W'(1)) begin
                                st        <= ST_IDLE;
                                pulse_cnt <= '0;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                pulse_cnt <= pulse_cnt - W'(1);
                            end
                        end
                    end else begin
                        ph <= ph + W'(1);
                    end
                end
            endcase
        end
    end

    assign state = st;

endmodule
